// File: rtl/sw_event_pkg.sv
// sw_event_pkg: handshake states, status code constants and code priority helper
package sw_event_pkg;
  typedef enum logic [1:0] {IDLE, POST, CLEAR} state_e;
  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_FRAME = 2'b01;
  localparam logic [1:0] CODE_HIT   = 2'b10;
  localparam logic [1:0] CODE_OVF   = 2'b11;
  function automatic logic [1:0] pick_code(input logic ovf, input logic hit, input logic frame);
    return ovf ? CODE_OVF : hit ? CODE_HIT : frame ? CODE_FRAME : CODE_NONE;
  endfunction
endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: saturating up/down event counter, flags increments lost at max
module sat_updown_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat_hit
);
  logic [W-1:0] count_q, count_d;
  logic at_max;
  always_comb begin
    at_max  = &count_q;
    count_d = (inc && !dec && !at_max) ? count_q + 1'b1
            : (dec && !inc && count_q != '0) ? count_q - 1'b1
            : count_q;
    sat_hit = inc && !dec && at_max;
  end
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/sw_event_handshake.sv
// sw_event_handshake: queues game events and posts them to software via a four-phase handshake
module sw_event_handshake
  import sw_event_pkg::*;
#(
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_done,
  input  logic              hit_event,
  input  logic [1:0]        from_sw_sig,
  output logic [1:0]        to_sw_sig,
  output logic [PEND_W-1:0] frame_pend,
  output logic [PEND_W-1:0] hit_pend,
  output logic              overflow,
  output logic              busy
);
  state_e state_q, state_d;
  logic [1:0] ack_q, code_q, code_d, out_q, out_d, sel;
  logic ovf_q, ovf_d, busy_q;
  logic dec_f, dec_h, clr_ovf, sat_f, sat_h;
  sat_updown_counter #(.W(PEND_W)) u_frame_cnt (
    .clk(clk), .reset(reset), .inc(frame_done), .dec(dec_f), .count(frame_pend), .sat_hit(sat_f)
  );
  sat_updown_counter #(.W(PEND_W)) u_hit_cnt (
    .clk(clk), .reset(reset), .inc(hit_event), .dec(dec_h), .count(hit_pend), .sat_hit(sat_h)
  );
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    out_d   = CODE_NONE;
    dec_f   = 1'b0;
    dec_h   = 1'b0;
    clr_ovf = 1'b0;
    sel     = pick_code(ovf_q, hit_pend != '0, frame_pend != '0);
    case (state_q)
      IDLE: if (sel != CODE_NONE) begin
        state_d = POST;
        code_d  = sel;
        out_d   = sel;
      end
      POST: if (ack_q == code_q) begin
        state_d = CLEAR;
        dec_f   = code_q == CODE_FRAME;
        dec_h   = code_q == CODE_HIT;
        clr_ovf = code_q == CODE_OVF;
      end else out_d = code_q;
      CLEAR: if (ack_q == CODE_NONE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a saturating event in the same cycle as the overflow ack keeps the flag set
    ovf_d = sat_f | sat_h | (ovf_q & ~clr_ovf);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= CODE_NONE;
      code_q  <= CODE_NONE;
      out_q   <= CODE_NONE;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= from_sw_sig;
      code_q  <= code_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      busy_q  <= state_d != IDLE;
    end
  end
  assign to_sw_sig = out_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
endmodule
